cipher_stress_harness: RTL and testbench

- Self-checking stress driver for an iterative block-cipher core with a start/finish handshake.
- Generates pseudorandom data and key words from internal LFSRs and issues a programmable number of operations back-to-back.
- Compresses every result into a MISR signature, so a bench or top-level compares one word instead of every output.
- Sits between test/top logic and any cipher core: AES128 encrypt/decrypt, or future wider cores.

---
 rtl/cipher_stress_harness.sv | 193 +++++++++++++++++++
 tb/tb_cipher_stress_harness.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_stress_harness.sv
// ---------------------------------------------------------------------------
// cipher_stress_harness
//
// Stress driver for an iterative block-cipher core with a start/finish
// handshake. Data and key words come from Galois LFSRs. A run issues
// i_num_ops operations back-to-back, and every result is folded into a MISR
// signature, so that only one word has to be compared at the end of a run.
//
// Optional feature: define CIPHER_STRESS_TIMEOUT_EN to add a per-operation
// WAIT watchdog. When the core does not answer within TIMEOUT cycles, the
// run ends in DONE with o_timeout_err set. When the macro is undefined,
// o_timeout_err is tied low and WAIT can last indefinitely.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_go, i_num_ops     start a run / number of operations (sampled in IDLE/DONE)
//   o_dut_start         one-cycle start pulse to the core
//   o_dut_in, o_dut_key plaintext and key driven to the core
//   i_dut_finish        core completion strobe; i_dut_out is valid with it
//   o_busy, o_done      run in progress / run complete (done is sticky)
//   o_op_count          number of operations completed in this run
//   o_signature         MISR of all results in this run
//   o_last_out          most recent captured result
//   o_timeout_err       sticky watchdog flag
//
// state  | meaning
// IDLE   | after reset, waiting for go
// ISSUE  | o_dut_start high for this single cycle
// WAIT   | waiting for i_dut_finish; the result is captured on that edge
// DONE   | run complete, results held, waiting for the next go
// ---------------------------------------------------------------------------
module cipher_stress_harness #(
    parameter int              DW        = 128,
    parameter int              KW        = 128,
    parameter int              CNT_W     = 16,
    parameter logic [DW-1:0]   DATA_POLY = {8'hE1, {(DW-8){1'b0}}},
    parameter logic [KW-1:0]   KEY_POLY  = {8'hE1, {(KW-8){1'b0}}},
    parameter logic [DW-1:0]   DATA_SEED = {{(DW-1){1'b0}}, 1'b1},
    parameter logic [KW-1:0]   KEY_SEED  = {{(KW-2){1'b0}}, 2'b10},
    parameter int              KEY_MODE  = 0,
    parameter int              TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic [CNT_W-1:0] i_num_ops,
    output logic             o_dut_start,
    output logic [DW-1:0]    o_dut_in,
    output logic [KW-1:0]    o_dut_key,
    input  logic             i_dut_finish,
    input  logic [DW-1:0]    i_dut_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_op_count,
    output logic [DW-1:0]    o_signature,
    output logic [DW-1:0]    o_last_out,
    output logic             o_timeout_err
);

    if (DW < 8 || KW < 8 || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("cipher_stress_harness: illegal parameter value");
    end

    // A zero seed would lock an LFSR at zero, so it is replaced by 1.
    localparam logic [DW-1:0] DSEED = (DATA_SEED == '0) ? {{(DW-1){1'b0}}, 1'b1} : DATA_SEED;
    localparam logic [KW-1:0] KSEED = (KEY_SEED == '0) ? {{(KW-1){1'b0}}, 1'b1} : KEY_SEED;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           r_state;
    logic             r_dut_start;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_num_ops;
    logic [CNT_W-1:0] r_op_count;
    logic [DW-1:0]    r_signature;
    logic [DW-1:0]    r_last_out;
    logic [DW-1:0]    r_data_lfsr;
    logic [KW-1:0]    r_key_lfsr;
    logic [CNT_W-1:0] w_op_next;

    assign w_op_next = r_op_count + 1'b1;

`ifdef CIPHER_STRESS_TIMEOUT_EN
    localparam int             TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout_err;
    assign o_timeout_err = r_timeout_err;
`else
    assign o_timeout_err = 1'b0;
`endif

    function automatic logic [DW-1:0] step_data(input logic [DW-1:0] x);
        return x[0] ? ((x >> 1) ^ DATA_POLY) : (x >> 1);
    endfunction

    function automatic logic [KW-1:0] step_key(input logic [KW-1:0] x);
        return x[0] ? ((x >> 1) ^ KEY_POLY) : (x >> 1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dut_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_num_ops   <= '0;
            r_op_count  <= '0;
            r_signature <= '0;
            r_last_out  <= '0;
            r_data_lfsr <= DSEED;
            r_key_lfsr  <= KSEED;
`ifdef CIPHER_STRESS_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_dut_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_go) begin
                        r_num_ops   <= i_num_ops;
                        r_op_count  <= '0;
                        r_signature <= '0;
                        r_data_lfsr <= DSEED;
                        r_key_lfsr  <= KSEED;
`ifdef CIPHER_STRESS_TIMEOUT_EN
                        r_timeout_err <= 1'b0;
`endif
                        if (i_num_ops == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_done      <= 1'b0;
                            r_busy      <= 1'b1;
                            r_dut_start <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
`ifdef CIPHER_STRESS_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (i_dut_finish) begin
                        // A finish arriving on the last watchdog cycle still wins.
                        r_last_out  <= i_dut_out;
                        r_signature <= {r_signature[DW-2:0], r_signature[DW-1]} ^ i_dut_out;
                        r_op_count  <= w_op_next;
                        r_data_lfsr <= step_data(r_data_lfsr);
                        if (KEY_MODE == 0) begin
                            r_key_lfsr <= step_key(r_key_lfsr);
                        end
                        if (w_op_next == r_num_ops) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_dut_start <= 1'b1;
                        end
                    end
`ifdef CIPHER_STRESS_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == TO_LAST) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= S_DONE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                        end
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_dut_start = r_dut_start;
    assign o_dut_in    = r_data_lfsr;
    assign o_dut_key   = r_key_lfsr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_op_count  = r_op_count;
    assign o_signature = r_signature;
    assign o_last_out  = r_last_out;

endmodule

// File: tb/tb_cipher_stress_harness.sv
// ---------------------------------------------------------------------------
// tb_cipher_stress_harness
//
// Testbench for cipher_stress_harness. It builds two harnesses side by side:
//   A: KEY_MODE=0, CNT_W=16
//   B: KEY_MODE=1, CNT_W=4
// Each harness drives its own echo core, which returns in ^ key a programmable
// number of cycles after start. A delay of 0 means the core never answers.
// TIMEOUT is 16 so the watchdog scenarios stay short when
// CIPHER_STRESS_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_cipher_stress_harness;

    localparam logic [127:0] POLY = {8'hE1, 120'b0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic [15:0]  num_a = '0;
    logic [3:0]   num_b;
    logic [4:0]   dly = 5'd3;
    logic         force_fin = 1'b0;

    logic         start_a, busy_a, done_a, terr_a, fin_a;
    logic [127:0] in_a, key_a, out_a, sig_a, last_a;
    logic [15:0]  cnt_out_a;
    logic         start_b, busy_b, done_b, terr_b, fin_b;
    logic [127:0] in_b, key_b, out_b, sig_b, last_b;
    logic [3:0]   cnt_out_b;

    logic [4:0]   core_a = '0, core_b = '0;
    int           starts_a = 0, starts_b = 0, key_bad_b = 0;
    logic [127:0] st_in_a = '0, st_key_a = '0;

    int n_checks = 0;
    int n_errors = 0;

    assign num_b = num_a[3:0];

    always #5 clk = ~clk;

    cipher_stress_harness #(.KEY_MODE(0), .CNT_W(16), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .rst(rst), .i_go(go), .i_num_ops(num_a),
        .o_dut_start(start_a), .o_dut_in(in_a), .o_dut_key(key_a),
        .i_dut_finish(fin_a), .i_dut_out(out_a),
        .o_busy(busy_a), .o_done(done_a), .o_op_count(cnt_out_a),
        .o_signature(sig_a), .o_last_out(last_a), .o_timeout_err(terr_a));

    cipher_stress_harness #(.KEY_MODE(1), .CNT_W(4), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .rst(rst), .i_go(go), .i_num_ops(num_b),
        .o_dut_start(start_b), .o_dut_in(in_b), .o_dut_key(key_b),
        .i_dut_finish(fin_b), .i_dut_out(out_b),
        .o_busy(busy_b), .o_done(done_b), .o_op_count(cnt_out_b),
        .o_signature(sig_b), .o_last_out(last_b), .o_timeout_err(terr_b));

    // Echo cores: the finish strobe fires dly cycles after start. They are
    // deliberately not reset, so a stale finish can land in IDLE.
    always @(posedge clk) begin
        if (start_a) core_a <= dly;
        else if (core_a != 0) core_a <= core_a - 1'b1;
        if (start_b) core_b <= dly;
        else if (core_b != 0) core_b <= core_b - 1'b1;
    end
    assign fin_a = (core_a == 5'd1) | force_fin;
    assign fin_b = (core_b == 5'd1) | force_fin;
    assign out_a = in_a ^ key_a;
    assign out_b = in_b ^ key_b;

    always @(posedge clk) begin
        if (start_a) begin
            starts_a <= starts_a + 1;
            st_in_a  <= in_a;
            st_key_a <= key_a;
        end
        if (start_b) starts_b <= starts_b + 1;
        if (start_b && key_b != 128'd2) key_bad_b <= key_bad_b + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] lstep(input logic [127:0] x);
        return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
    endfunction

    function automatic logic [127:0] model_sig(input int n, input int km);
        logic [127:0] d, k, s;
        d = 128'd1; k = 128'd2; s = '0;
        for (int i = 0; i < n; i++) begin
            s = {s[126:0], s[127]} ^ (d ^ k);
            d = lstep(d);
            if (km == 0) k = lstep(k);
        end
        return s;
    endfunction

    // Issues go for one clock edge and returns at the negedge after that edge.
    task automatic run(input int n);
        @(negedge clk);
        go = 1'b1;
        num_a = 16'(n);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!(done_a && done_b) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", {127'b0, done_a && done_b}, 128'd1);
    endtask

    int cyc;
    int s0;
    logic [127:0] sig5_a, sig5_b;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_done",  {127'b0, done_a}, 128'd0);
        check("rst_busy",  {127'b0, busy_a}, 128'd0);
        check("rst_cnt",   {112'b0, cnt_out_a}, 128'd0);
        check("rst_sig",   sig_a, 128'd0);
        check("rst_last",  last_a, 128'd0);
        check("rst_in",    in_a, 128'd1);
        check("rst_key",   key_a, 128'd2);
        check("rst_start", {127'b0, start_a}, 128'd0);
        check("rst_terr",  {127'b0, terr_a}, 128'd0);

        // Stray finish in IDLE.
        force_fin = 1'b1;
        @(negedge clk);
        force_fin = 1'b0;
        @(negedge clk);
        check("idle_fin_cnt",  {112'b0, cnt_out_a}, 128'd0);
        check("idle_fin_sig",  sig_a, 128'd0);
        check("idle_fin_last", last_a, 128'd0);
        check("idle_fin_done", {127'b0, done_a}, 128'd0);

        // num_ops = 0
        s0 = starts_a;
        run(0);
        check("zero_done",   {127'b0, done_a}, 128'd1);
        check("zero_busy",   {127'b0, busy_a}, 128'd0);
        repeat (4) @(negedge clk);
        check("zero_starts", 128'(starts_a - s0), 128'd0);
        check("zero_cnt",    {112'b0, cnt_out_a}, 128'd0);
        check("zero_sig",    sig_a, 128'd0);

        // num_ops = 1
        s0 = starts_a;
        run(1);
        check("one_busy", {127'b0, busy_a}, 128'd1);
        wait_done(50, cyc);
        check("one_starts", 128'(starts_a - s0), 128'd1);
        check("one_st_in",  st_in_a, 128'd1);
        check("one_st_key", st_key_a, 128'd2);
        check("one_sig_a",  sig_a, 128'd3);
        check("one_last_a", last_a, 128'd3);
        check("one_cnt_a",  {112'b0, cnt_out_a}, 128'd1);
        check("one_sig_b",  sig_b, 128'd3);

        // num_ops = 2, hand-computed
        run(2);
        wait_done(50, cyc);
        check("two_sig_a",  sig_a,  {8'hE1, 112'b0, 8'h07});
        check("two_last_a", last_a, {8'hE1, 112'b0, 8'h01});
        check("two_sig_b",  sig_b,  {8'hE1, 112'b0, 8'h04});
        check("two_last_b", last_b, {8'hE1, 112'b0, 8'h02});

        // num_ops = 5, both key modes
        s0 = starts_a;
        run(5);
        wait_done(100, cyc);
        check("five_starts", 128'(starts_a - s0), 128'd5);
        check("five_cnt_a",  {112'b0, cnt_out_a}, 128'd5);
        check("five_sig_a",  sig_a, model_sig(5, 0));
        check("five_sig_b",  sig_b, model_sig(5, 1));
        check("five_key_b",  key_b, 128'd2);
        sig5_a = sig_a;
        sig5_b = sig_b;

        // Stray finish in DONE.
        force_fin = 1'b1;
        @(negedge clk);
        force_fin = 1'b0;
        @(negedge clk);
        check("done_fin_cnt", {112'b0, cnt_out_a}, 128'd5);
        check("done_fin_sig", sig_a, sig5_a);

        // Repeat run, with go pulsed (num_ops=1) during WAIT of op 1.
        run(5);
        @(negedge clk);
        go = 1'b1; num_a = 16'd1;
        @(negedge clk);
        go = 1'b0;
        wait_done(100, cyc);
        check("rerun_cnt_a", {112'b0, cnt_out_a}, 128'd5);
        check("rerun_sig_a", sig_a, sig5_a);
        check("rerun_sig_b", sig_b, sig5_b);

        // Reset during WAIT of op 3 of 5.
        s0 = starts_a;
        run(5);
        cyc = 0;
        while (starts_a < s0 + 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid_reach", 128'(starts_a - s0), 128'd3);
        check("rstmid_busy_pre", {127'b0, busy_a}, 128'd1);
        rst = 1'b1;
        #1;
        check("rstmid_busy", {127'b0, busy_a}, 128'd0);
        check("rstmid_cnt",  {112'b0, cnt_out_a}, 128'd0);
        check("rstmid_sig",  sig_a, 128'd0);
        check("rstmid_last", last_a, 128'd0);
        check("rstmid_in",   in_a, 128'd1);
        check("rstmid_key",  key_a, 128'd2);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstmid_stale_cnt",  {112'b0, cnt_out_a}, 128'd0);
        check("rstmid_stale_done", {127'b0, done_a}, 128'd0);
        run(5);
        wait_done(100, cyc);
        check("rstmid_sig_a", sig_a, model_sig(5, 0));
        check("rstmid_sig_b", sig_b, sig5_b);

        // Largest run for the 4-bit counter in B: ends at 15 without wrapping.
        run(15);
        wait_done(300, cyc);
        check("max_cnt_b", {124'b0, cnt_out_b}, 128'd15);
        check("max_sig_b", sig_b, model_sig(15, 1));
        check("max_sig_a", sig_a, model_sig(15, 0));
        check("key_const_b", 128'(key_bad_b), 128'd0);

`ifdef CIPHER_STRESS_TIMEOUT_EN
        // The core never answers: the watchdog fires after 16 WAIT cycles.
        dly = 5'd0;
        run(1);
        wait_done(60, cyc);
        check("to_cycles", 128'(cyc), 128'd17);
        check("to_err",    {127'b0, terr_a}, 128'd1);
        check("to_cnt",    {112'b0, cnt_out_a}, 128'd0);
        check("to_sig",    sig_a, 128'd0);
        check("to_busy",   {127'b0, busy_a}, 128'd0);
        // A finish on the 16th WAIT cycle wins over the watchdog.
        dly = 5'd16;
        run(1);
        wait_done(60, cyc);
        check("to_edge_err", {127'b0, terr_a}, 128'd0);
        check("to_edge_cnt", {112'b0, cnt_out_a}, 128'd1);
        check("to_edge_sig", sig_a, 128'd3);
        dly = 5'd3;
`else
        check("terr_tied", {127'b0, terr_a | terr_b}, 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
